// File: rtl/md_if.sv
// Handshake and data bundle between the E-stage decoder and the
// multiply/divide sequencer that owns HI/LO.
interface md_if;
  logic        start;
  logic [1:0]  op;
  logic        madd;
  logic [31:0] a;
  logic [31:0] b;
  logic        mtwrite;
  logic        mtsel;
  logic [31:0] mtdata;
  logic        flush;
  logic        md_inD;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, madd, a, b, mtwrite, mtsel, mtdata, flush, md_inD,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, madd, a, b, mtwrite, mtsel, mtdata, flush, md_inD,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// The arithmetic result is computed when an operation is accepted and held
// in a shadow register; the FSM only models latency and decides whether
// that result is committed (or accumulated, for MADD) or discarded on flush.
module md_sequencer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  md_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               maddLat;
  logic [31:0]        hiReg;
  logic [31:0]        loReg;
  logic [63:0]        result_p0;
  logic [63:0]        startResult;
  logic [CNT_W-1:0]   startCnt;
  logic               isDiv;
  logic               accept;

  // 64-bit product; signed operands are sign-extended so the truncated
  // 64-bit product is the exact two's-complement result.
  function automatic logic [63:0] mulResult(input logic isSigned,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic        [63:0] ux;
    logic        [63:0] uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (isSigned) mulResult = 64'(sx * sy);
    else          mulResult = ux * uy;
  endfunction

  // Returns {remainder, quotient}. Divide by zero yields all-ones quotient
  // and the dividend as remainder; the one signed overflow case is pinned
  // explicitly so the native divider never sees it.
  function automatic logic [63:0] divResult(input logic isSigned,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sx = x;
    sy = y;
    if (y == 32'h0) begin
      divResult = {x, 32'hFFFF_FFFF};
    end else if (isSigned) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        divResult = {32'h0, 32'h8000_0000};
      end else begin
        sq = sx / sy;
        sr = sx % sy;
        divResult = {sr, sq};
      end
    end else begin
      divResult = {x % y, x / y};
    end
  endfunction

  assign isDiv       = bus.op[1] & ~bus.madd;
  assign accept      = (state == IDLE) & bus.start & ~bus.flush;
  assign startResult = isDiv ? divResult(bus.op[0], bus.a, bus.b)
                             : mulResult(bus.op[0] | bus.madd, bus.a, bus.b);
  assign startCnt    = isDiv ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);

  // Stage p0: capture the operation's result when it is accepted
  always_ff @(posedge clk) begin
    if (accept) result_p0 <= startResult;
  end

  // Control FSM: latency counter, commit/discard, and MTHI/MTLO writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      maddLat <= 1'b0;
      hiReg   <= 32'h0;
      loReg   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= RUN;
            cnt     <= startCnt;
            maddLat <= bus.madd;
          end else if (bus.mtwrite && !bus.start) begin
            if (bus.mtsel) hiReg <= bus.mtdata;
            else           loReg <= bus.mtdata;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= IDLE;
            if (maddLat) {hiReg, loReg} <= {hiReg, loReg} + result_p0;
            else         {hiReg, loReg} <= result_p0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.stall = bus.md_inD & ((state == RUN) | bus.start);
  assign bus.hi    = hiReg;
  assign bus.lo    = loReg;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vector table, hand-written corner-case
// sequences, and randomized operations against an arithmetic reference.
module tb_md_sequencer;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   violations = 0;

  md_if mdBus();

  md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mdBus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Protocol monitor: starting a new operation while one is in flight
  always @(posedge clk) begin
    if (rst_n && mdBus.start && mdBus.busy) begin
      violations++;
      $display("protocol violation: start while busy at %0t", $time);
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        madd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] preHi;
    logic [31:0] preLo;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic mtWrite(input logic sel, input logic [31:0] data);
    mdBus.mtwrite = 1'b1;
    mdBus.mtsel   = sel;
    mdBus.mtdata  = data;
    tick();
    mdBus.mtwrite = 1'b0;
  endtask

  // Starts one operation, then counts busy cycles. hi/lo must hold their
  // previous values for the whole time busy is high. Optional flush on the
  // given busy cycle (1-based), or -1 for none.
  task automatic runOp(input logic [1:0] op, input logic madd,
                       input logic [31:0] a, input logic [31:0] b,
                       input int flushAt,
                       output int busyCnt, output bit heldOld);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = mdBus.hi;
    l0 = mdBus.lo;
    mdBus.start = 1'b1;
    mdBus.op    = op;
    mdBus.madd  = madd;
    mdBus.a     = a;
    mdBus.b     = b;
    tick();
    mdBus.start = 1'b0;
    mdBus.madd  = 1'b0;
    busyCnt = 0;
    heldOld = 1'b1;
    while (mdBus.busy && busyCnt < 40) begin
      busyCnt++;
      if (mdBus.hi !== h0 || mdBus.lo !== l0) heldOld = 1'b0;
      if (busyCnt == flushAt) mdBus.flush = 1'b1;
      tick();
      mdBus.flush = 1'b0;
    end
  endtask

  function automatic int latOf(input logic [1:0] op, input logic madd);
    return (op[1] && !madd) ? DIV_LAT : MULT_LAT;
  endfunction

  // Reference: wide integer arithmetic. Division uses 64-bit quotients so
  // the signed overflow case falls out naturally; remainder is a - q*b.
  function automatic logic [63:0] modelOp(input logic [1:0] op, input logic madd,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     q;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (madd) return {hi, lo} + 64'(sa * sb);
    case (op)
      2'b00: return 64'(ua * ub);
      2'b01: return 64'(sa * sb);
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = ua / ub;
          r = ua - q * ub;
        end else begin
          q = sa / sb;
          r = sa - longint'(q) * sb;
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  initial begin
    int          busyCnt;
    bit          held;
    int          n;
    int          v0;
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [63:0] exp64;

    vecs[0]  = '{"mult_neg",       2'b01, 1'b0, 32'hFFFF_FFFE, 32'h3,         32'h0,        32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{"multu_max",      2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{"div_neg7_2",     2'b11, 1'b0, 32'hFFFF_FFF9, 32'h2,         32'h0,        32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"div_ovf",        2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1,        32'h1, 32'h0,         32'h8000_0000};
    vecs[4]  = '{"divu_by0",       2'b10, 1'b0, 32'h1234_ABCD, 32'h0,         32'h0,        32'h0, 32'h1234_ABCD, 32'hFFFF_FFFF};
    vecs[5]  = '{"madd_2x3",       2'b01, 1'b1, 32'h2,         32'h3,         32'h1234_5678, 32'h5, 32'h1234_5678, 32'h0000_000B};
    vecs[6]  = '{"div_by0_signed", 2'b11, 1'b0, 32'h8000_0001, 32'h0,         32'h0,        32'h0, 32'h8000_0001, 32'hFFFF_FFFF};
    vecs[7]  = '{"madd_carry",     2'b01, 1'b1, 32'h1,         32'h1,         32'h0,        32'hFFFF_FFFF, 32'h1, 32'h0};
    vecs[8]  = '{"madd_neg",       2'b01, 1'b1, 32'hFFFF_FFFF, 32'h1,         32'h0,        32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[9]  = '{"div_7_neg2",     2'b11, 1'b0, 32'h7,         32'hFFFF_FFFE, 32'h0,        32'h0, 32'h1,         32'hFFFF_FFFD};
    vecs[10] = '{"divu_100_7",     2'b10, 1'b0, 32'd100,       32'd7,         32'h0,        32'h0, 32'h2,         32'hE};

    mdBus.start   = 1'b0;
    mdBus.op      = 2'b00;
    mdBus.madd    = 1'b0;
    mdBus.a       = 32'h0;
    mdBus.b       = 32'h0;
    mdBus.mtwrite = 1'b0;
    mdBus.mtsel   = 1'b0;
    mdBus.mtdata  = 32'h0;
    mdBus.flush   = 1'b0;
    mdBus.md_inD  = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();

    // Reset state; stall must stay low with an md instruction in D but no start
    mdBus.md_inD = 1'b1;
    #1;
    check("reset_busy",  64'(mdBus.busy),  64'h0);
    check("reset_stall", 64'(mdBus.stall), 64'h0);
    check("reset_hi",    64'(mdBus.hi),    64'h0);
    check("reset_lo",    64'(mdBus.lo),    64'h0);
    mdBus.md_inD = 1'b0;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      mtWrite(1'b1, vecs[i].preHi);
      mtWrite(1'b0, vecs[i].preLo);
      runOp(vecs[i].op, vecs[i].madd, vecs[i].a, vecs[i].b, -1, busyCnt, held);
      check({vecs[i].name, "_busy"}, 64'(busyCnt), 64'(latOf(vecs[i].op, vecs[i].madd)));
      check({vecs[i].name, "_hold"}, 64'(held), 64'h1);
      check({vecs[i].name, "_hi"},   64'(mdBus.hi), 64'(vecs[i].expHi));
      check({vecs[i].name, "_lo"},   64'(mdBus.lo), 64'(vecs[i].expLo));
    end

    // Flush on the second RUN cycle: no commit, busy drops at that edge
    mtWrite(1'b1, 32'hAAAA_0001);
    mtWrite(1'b0, 32'hBBBB_0002);
    runOp(2'b01, 1'b0, 32'h7, 32'h9, 2, busyCnt, held);
    check("flush_busy", 64'(busyCnt), 64'h2);
    repeat (MULT_LAT + 1) tick();
    check("flush_hi", 64'(mdBus.hi), 64'hAAAA_0001);
    check("flush_lo", 64'(mdBus.lo), 64'hBBBB_0002);
    mdBus.md_inD = 1'b1;
    #1;
    check("flush_idle_stall", 64'(mdBus.stall), 64'h0);
    mdBus.md_inD = 1'b0;

    // Flush together with start: start is ignored
    mdBus.start = 1'b1;
    mdBus.flush = 1'b1;
    mdBus.op    = 2'b11;
    tick();
    mdBus.start = 1'b0;
    mdBus.flush = 1'b0;
    check("flush_start_busy", 64'(mdBus.busy), 64'h0);

    // start and mtwrite together (start wins), mtwrite held through RUN (dropped)
    mtWrite(1'b1, 32'h55);
    mdBus.mtwrite = 1'b1;
    mdBus.mtsel   = 1'b1;
    mdBus.mtdata  = 32'hDEAD_BEEF;
    runOp(2'b01, 1'b0, 32'h2, 32'h3, -1, busyCnt, held);
    mdBus.mtwrite = 1'b0;
    check("start_mt_hi", 64'(mdBus.hi), 64'h0);
    check("start_mt_lo", 64'(mdBus.lo), 64'h6);

    // mtwrite during RUN then flush: LO keeps its old value
    mtWrite(1'b0, 32'h2222);
    mdBus.mtwrite = 1'b1;
    mdBus.mtsel   = 1'b0;
    mdBus.mtdata  = 32'hBAD;
    #1;
    mdBus.mtwrite = 1'b0;
    runOp(2'b00, 1'b0, 32'h3, 32'h3, 1, busyCnt, held);
    mdBus.mtwrite = 1'b0;
    check("mt_busy_lo", 64'(mdBus.lo), 64'h2222);
    // second variant: mtwrite raised only while busy
    mdBus.start = 1'b1;
    mdBus.op    = 2'b00;
    mdBus.a     = 32'h3;
    mdBus.b     = 32'h3;
    tick();
    mdBus.start   = 1'b0;
    mdBus.mtwrite = 1'b1;
    mdBus.mtdata  = 32'hBAD;
    tick();
    mdBus.mtwrite = 1'b0;
    mdBus.flush   = 1'b1;
    tick();
    mdBus.flush = 1'b0;
    check("mt_in_run_lo", 64'(mdBus.lo), 64'h2222);

    // start while busy: ignored, flagged by the monitor
    v0 = violations;
    mdBus.start = 1'b1;
    mdBus.op    = 2'b01;
    mdBus.a     = 32'h2;
    mdBus.b     = 32'h3;
    tick();
    mdBus.op = 2'b10;
    mdBus.a  = 32'd100;
    mdBus.b  = 32'd7;
    tick();
    mdBus.start = 1'b0;
    n = 2;
    while (mdBus.busy && n < 40) begin
      n++;
      tick();
    end
    check("start_busy_len", 64'(n - 1), 64'(MULT_LAT));
    check("start_busy_lo",  64'(mdBus.lo), 64'h6);
    check("start_busy_flag", 64'(violations), 64'(v0 + 1));

    // md_inD held over a DIV: stall in the start cycle, then for every busy cycle
    mdBus.md_inD = 1'b1;
    mdBus.start  = 1'b1;
    mdBus.op     = 2'b10;
    mdBus.a      = 32'd100;
    mdBus.b      = 32'd7;
    #1;
    check("stall_start_cycle", 64'(mdBus.stall), 64'h1);
    tick();
    mdBus.start = 1'b0;
    n = 0;
    while (mdBus.stall && n < 40) begin
      n++;
      tick();
    end
    check("stall_busy_cycles", 64'(n), 64'(DIV_LAT));
    check("stall_div_lo", 64'(mdBus.lo), 64'hE);

    // Asynchronous reset in the middle of a DIV
    mdBus.start = 1'b1;
    mdBus.op    = 2'b11;
    mdBus.a     = 32'hFFFF_FFF9;
    mdBus.b     = 32'h2;
    tick();
    mdBus.start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  64'(mdBus.busy),  64'h0);
    check("arst_stall", 64'(mdBus.stall), 64'h0);
    check("arst_hi",    64'(mdBus.hi),    64'h0);
    check("arst_lo",    64'(mdBus.lo),    64'h0);
    #2 rst_n = 1'b1;
    mdBus.md_inD = 1'b0;
    repeat (DIV_LAT + 2) tick();
    check("arst_no_commit_lo", 64'(mdBus.lo), 64'h0);

    // Randomized operations against the reference model
    mHi = $urandom;
    mLo = $urandom;
    mtWrite(1'b1, mHi);
    mtWrite(1'b0, mLo);
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic        madd;
      logic [31:0] a;
      logic [31:0] b;
      int          flushAt;
      int          expBusy;
      if ($urandom_range(0, 9) < 3) begin
        logic        sel;
        logic [31:0] d;
        sel = 1'($urandom_range(0, 1));
        d   = $urandom;
        mtWrite(sel, d);
        if (sel) mHi = d;
        else     mLo = d;
      end
      op   = 2'($urandom_range(0, 3));
      madd = (op == 2'b01) && ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      flushAt = ($urandom_range(0, 7) == 0) ? $urandom_range(1, latOf(op, madd)) : -1;
      expBusy = (flushAt > 0) ? flushAt : latOf(op, madd);
      runOp(op, madd, a, b, flushAt, busyCnt, held);
      if (flushAt < 0) begin
        exp64 = modelOp(op, madd, a, b, mHi, mLo);
        mHi = exp64[63:32];
        mLo = exp64[31:0];
      end
      check($sformatf("rnd%0d_busy", i), 64'(busyCnt), 64'(expBusy));
      check($sformatf("rnd%0d_hilo", i), {mdBus.hi, mdBus.lo}, {mHi, mLo});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
